dv_stim_seq: RTL and testbench

Stimulus sequencer for the simulation harness. It sits directly downstream of the harness controller. It waits for the controller's level `start`, then replays a preloaded list of commands into the DUT over a valid/ready port, each command after its own programmed delay. It counts DUT responses and reports `cmds_done` and `test_done` back to the controller, which uses them to end the simulation. A timeout flags a hung DUT instead of letting the run stall.

---
 rtl/dv_stim_seq.sv | 185 ++++++++++++++++++
 tb/tb_dv_stim_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dv_stim_seq.sv
// Stimulus sequencer: replays a preloaded command list into a DUT over valid/ready,
// counts responses and reports completion, overflow and DRAIN timeout to the harness.
module dv_stim_seq #(
    parameter int AW      = 6,
    parameter int DW      = 32,
    parameter int DLW     = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DLW+DW-1:0] load_data,
    input  logic [AW:0]       num_cmds,
    output logic              stim_valid,
    output logic [DW-1:0]     stim_data,
    input  logic              stim_ready,
    input  logic              resp_valid,
    output logic [AW:0]       resp_count,
    output logic              cmds_done,
    output logic              test_done,
    output logic              timeout_err,
    output logic              resp_err
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0] RESP_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        SEND,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [DLW+DW-1:0] mem [2**AW];

    logic [AW:0]     idx, idx_n;
    logic [DLW-1:0]  dcnt, dcnt_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic [AW:0]     num_cmds_q, num_cmds_q_n;
    logic [AW:0]     resp_count_n;
    logic            cmds_done_n, test_done_n, timeout_err_n, resp_err_n;

    logic [AW-1:0]   nxt_addr;
    logic [DLW-1:0]  dly_cur, dly_nxt;
    logic [DW-1:0]   pay_cur;
    logic            resp_hit;

    // The array is deliberately left out of reset so a run can be replayed after an abort.
    always_ff @(posedge clk) begin
        if (load_en && state == IDLE) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        nxt_addr = idx[AW-1:0] + AW'(1);
        dly_cur  = mem[idx[AW-1:0]][DLW+DW-1:DW];
        pay_cur  = mem[idx[AW-1:0]][DW-1:0];
        dly_nxt  = mem[nxt_addr][DLW+DW-1:DW];
    end

    assign stim_valid = (state == SEND);
    assign stim_data  = (state == SEND) ? pay_cur : '0;

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        dcnt_n        = dcnt;
        tcnt_n        = tcnt;
        num_cmds_q_n  = num_cmds_q;
        resp_count_n  = resp_count;
        cmds_done_n   = cmds_done;
        test_done_n   = test_done;
        timeout_err_n = timeout_err;
        resp_err_n    = resp_err;

        resp_hit = resp_valid && (state != IDLE);
        if (resp_hit) begin
            if (resp_count == num_cmds_q) begin
                resp_err_n = 1'b1;
            end
            if (resp_count != RESP_MAX) begin
                resp_count_n = resp_count + (AW+1)'(1);
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    num_cmds_q_n = num_cmds;
                    idx_n        = '0;
                    if (num_cmds == '0) begin
                        state_n     = DRAIN;
                        cmds_done_n = 1'b1;
                        tcnt_n      = '0;
                    end else if (dly_cur == '0) begin
                        state_n = SEND;
                    end else begin
                        state_n = DELAY;
                        dcnt_n  = dly_cur;
                    end
                end
            end

            DELAY: begin
                dcnt_n = dcnt - DLW'(1);
                if (dcnt == DLW'(1)) begin
                    state_n = SEND;
                end
            end

            SEND: begin
                if (stim_ready) begin
                    if (idx == num_cmds_q - (AW+1)'(1)) begin
                        state_n     = DRAIN;
                        cmds_done_n = 1'b1;
                        tcnt_n      = '0;
                    end else begin
                        idx_n = idx + (AW+1)'(1);
                        if (dly_nxt == '0) begin
                            state_n = SEND;
                        end else begin
                            state_n = DELAY;
                            dcnt_n  = dly_nxt;
                        end
                    end
                end
            end

            DRAIN: begin
                tcnt_n = tcnt + TW'(1);
                // Completion uses this cycle's response too, so the last response ends DRAIN directly.
                if (resp_count_n >= num_cmds_q) begin
                    state_n     = DONE;
                    test_done_n = 1'b1;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_n       = DONE;
                    test_done_n   = 1'b1;
                    timeout_err_n = 1'b1;
                end
            end

            DONE: begin
                state_n = DONE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            dcnt        <= '0;
            tcnt        <= '0;
            num_cmds_q  <= '0;
            resp_count  <= '0;
            cmds_done   <= 1'b0;
            test_done   <= 1'b0;
            timeout_err <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dcnt        <= dcnt_n;
            tcnt        <= tcnt_n;
            num_cmds_q  <= num_cmds_q_n;
            resp_count  <= resp_count_n;
            cmds_done   <= cmds_done_n;
            test_done   <= test_done_n;
            timeout_err <= timeout_err_n;
            resp_err    <= resp_err_n;
        end
    end

endmodule

// File: tb/tb_dv_stim_seq.sv
// Bench for dv_stim_seq: directed and randomized runs checked every cycle against a
// timeline model (issue times, response counts, drain deadline) derived from the command list.
module tb_dv_stim_seq;

    localparam int AW      = 6;
    localparam int DW      = 32;
    localparam int DLW     = 8;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [DLW+DW-1:0] load_data;
    logic [AW:0]       num_cmds;
    logic              stim_valid;
    logic [DW-1:0]     stim_data;
    logic              stim_ready;
    logic              resp_valid;
    logic [AW:0]       resp_count;
    logic              cmds_done;
    logic              test_done;
    logic              timeout_err;
    logic              resp_err;

    dv_stim_seq #(.AW(AW), .DW(DW), .DLW(DLW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .num_cmds   (num_cmds),
        .stim_valid (stim_valid),
        .stim_data  (stim_data),
        .stim_ready (stim_ready),
        .resp_valid (resp_valid),
        .resp_count (resp_count),
        .cmds_done  (cmds_done),
        .test_done  (test_done),
        .timeout_err(timeout_err),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int unsigned m_dly [DEPTH];
    logic [DW-1:0] m_pay [DEPTH];

    int obs_v_cyc;
    int obs_cd_cyc;
    int obs_td_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":valid"},   stim_valid,  0);
        chk({tag, ":data"},    stim_data,   0);
        chk({tag, ":cd"},      cmds_done,   0);
        chk({tag, ":td"},      test_done,   0);
        chk({tag, ":to"},      timeout_err, 0);
        chk({tag, ":re"},      resp_err,    0);
        chk({tag, ":rc"},      resp_count,  0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        num_cmds   = '0;
        stim_ready = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset("rst");
    endtask

    task automatic load(input int unsigned a, input int unsigned d, input logic [DW-1:0] p);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = {DLW'(d), p};
        @(negedge clk);
        load_en = 1'b0;
        m_dly[a] = d;
        m_pay[a] = p;
    endtask

    // Cycle c counts periods after the edge that first samples start (c=1 is the period after it).
    task automatic run(input string tag, input int n, input int rdy_pct, input int rsp_pct,
                       input int extra, input int drop, input int stall_idx, input bit abort_run,
                       input bit ld0, input int unsigned ld_a, input int unsigned ld_d,
                       input logic [DW-1:0] ld_p);
        int  issued, next_valid, done_cyc, sent, budget, allowed, stall_left, tail, e_rc;
        bit  e_cd, e_td, e_to, e_re, cd_now, stall_done, vexp, hs, rsp, fin, aborted;
        issued = 0; sent = 0; stall_left = 0; tail = 0; e_rc = 0;
        e_cd = 0; e_td = 0; e_to = 0; e_re = 0; stall_done = 0; fin = 0; aborted = 0;
        done_cyc = 0; next_valid = 0;
        obs_v_cyc = -1; obs_cd_cyc = -1; obs_td_cyc = -1;
        budget = n - drop + extra;

        start    = 1'b1;
        num_cmds = (AW+1)'(n);
        if (n == 0) begin
            e_cd     = 1;
            done_cyc = 1;
        end else begin
            next_valid = 1 + int'(m_dly[0]);
        end
        if (ld0) begin
            load_en   = 1'b1;
            load_addr = AW'(ld_a);
            load_data = {DLW'(ld_d), ld_p};
            m_dly[ld_a] = ld_d;
            m_pay[ld_a] = ld_p;
        end
        @(negedge clk);

        for (int c = 1; c <= 3000 && !fin; c++) begin
            vexp = (issued < n) && (c >= next_valid);
            chk({tag, ":valid"}, stim_valid, vexp);
            chk({tag, ":data"},  stim_data, vexp ? m_pay[issued] : '0);
            chk({tag, ":cd"},    cmds_done, e_cd);
            chk({tag, ":td"},    test_done, e_td);
            chk({tag, ":to"},    timeout_err, e_to);
            chk({tag, ":re"},    resp_err, e_re);
            chk({tag, ":rc"},    resp_count, e_rc);
            if (stim_valid === 1'b1 && obs_v_cyc < 0) obs_v_cyc = c;
            if (cmds_done === 1'b1 && obs_cd_cyc < 0) obs_cd_cyc = c;
            if (test_done === 1'b1 && obs_td_cyc < 0) obs_td_cyc = c;

            if (abort_run && issued == 2 && c < next_valid) begin
                reset      = 1'b1;
                start      = 1'b0;
                load_en    = 1'b0;
                stim_ready = 1'b0;
                resp_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                chk_reset({tag, ":abort"});
                aborted = 1;
                break;
            end

            // Writes and num_cmds changes here must have no effect outside IDLE.
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = AW'($urandom);
            load_data = {DLW'($urandom), DW'($urandom)};
            num_cmds  = (AW+1)'($urandom);

            if (vexp && issued == stall_idx && !stall_done && stall_left == 0) stall_left = 7;
            if (stall_left > 0) begin
                stim_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) stall_done = 1;
            end else begin
                stim_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            hs = vexp && stim_ready;
            if (hs) begin
                issued++;
                if (issued == n) done_cyc = c + 1;
                else next_valid = c + 1 + int'(m_dly[issued]);
            end

            allowed = issued + extra;
            if (allowed > budget) allowed = budget;
            rsp = (sent < allowed) && ($urandom_range(0, 99) < rsp_pct);
            resp_valid = rsp;

            cd_now = e_cd;
            if (rsp) begin
                sent++;
                if (e_rc == n) e_re = 1;
                if (e_rc < DEPTH) e_rc++;
            end
            if (cd_now && !e_td) begin
                if (e_rc >= n) begin
                    e_td = 1;
                end else if (c - done_cyc == TIMEOUT - 1) begin
                    e_td = 1;
                    e_to = 1;
                end
            end
            if (hs && issued == n) e_cd = 1;

            if (e_td && sent == budget) tail++;
            if (tail >= 3) fin = 1;
            @(negedge clk);
        end

        load_en    = 1'b0;
        resp_valid = 1'b0;
        stim_ready = 1'b0;
        if (!aborted) begin
            checks++;
            assert (fin) else begin
                errors++;
                $error("FAIL %s:bound observed=unfinished expected=finished", tag);
            end
        end
    endtask

    initial begin
        do_reset();

        // Four back-to-back commands with immediate responses.
        for (int i = 0; i < 4; i++) load(i, 0, 32'h10 + i);
        run("t1", 4, 100, 100, 0, 0, -1, 0, 0, 0, 0, '0);
        chk("t1:rc_final", resp_count, 4);
        chk("t1:first_valid", obs_v_cyc, 1);
        chk("t1:cd_cycle", obs_cd_cyc, 5);
        chk("t1:td_cycle", obs_td_cyc, 6);

        // First-entry delay of 5.
        do_reset();
        load(0, 5, $urandom);
        load(1, 0, $urandom);
        load(2, 2, $urandom);
        run("t2", 3, 100, 100, 0, 0, -1, 0, 0, 0, 0, '0);
        chk("t2:first_valid", obs_v_cyc, 6);

        // Seven-cycle backpressure on the second command.
        do_reset();
        load(0, 1, $urandom);
        load(1, 0, $urandom);
        load(2, 3, $urandom);
        load(3, 0, $urandom);
        run("t3", 4, 100, 100, 0, 0, 1, 0, 0, 0, 0, '0);

        // One response missing: drain times out.
        do_reset();
        load(0, 0, $urandom);
        load(1, 0, $urandom);
        run("t4", 2, 100, 100, 0, 1, -1, 0, 0, 0, 0, '0);
        chk("t4:to_final", timeout_err, 1);
        chk("t4:td_final", test_done, 1);
        chk("t4:rc_final", resp_count, 1);
        chk("t4:drain_len", obs_td_cyc - obs_cd_cyc, TIMEOUT);

        // One response too many.
        do_reset();
        run("t5", 2, 100, 100, 1, 0, -1, 0, 0, 0, 0, '0);
        chk("t5:re_final", resp_err, 1);
        chk("t5:rc_final", resp_count, 3);
        chk("t5:to_final", timeout_err, 0);

        // Reset while delaying the third command, then replay from the retained memory.
        do_reset();
        load(0, 0, $urandom);
        load(1, 1, $urandom);
        load(2, 6, $urandom);
        load(3, 2, $urandom);
        load(4, 0, $urandom);
        run("t6a", 5, 100, 100, 0, 0, -1, 1, 0, 0, 0, '0);
        run("t6b", 5, 100, 100, 0, 0, -1, 0, 0, 0, 0, '0);
        chk("t6b:rc_final", resp_count, 5);

        // Write to entry 0 on the start edge: old delay, new payload.
        do_reset();
        load(0, 3, 32'hAAAA_0000);
        load(1, 0, 32'hBBBB_0001);
        run("t7", 2, 100, 100, 0, 0, -1, 0, 1, 0, 0, 32'hCCCC_0002);
        chk("t7:first_valid", obs_v_cyc, 4);

        // Maximum delay value.
        do_reset();
        load(0, 0, $urandom);
        load(1, 255, $urandom);
        run("t8", 2, 100, 100, 0, 0, -1, 0, 0, 0, 0, '0);

        // Full-depth list.
        do_reset();
        for (int i = 0; i < DEPTH; i++) load(i, 0, $urandom);
        run("t9", DEPTH, 100, 100, 0, 0, -1, 0, 0, 0, 0, '0);
        chk("t9:rc_final", resp_count, DEPTH);

        // Empty list.
        do_reset();
        run("t10", 0, 100, 100, 0, 0, -1, 0, 0, 0, 0, '0);
        chk("t10:cd_cycle", obs_cd_cyc, 1);
        chk("t10:td_cycle", obs_td_cyc, 2);

        // Randomized lists with random backpressure and response timing.
        for (int r = 0; r < 8; r++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) begin
                load(i, ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4), $urandom);
            end
            run("rnd", n, 60, 50, 0, 0, -1, 0, 0, 0, 0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
